// File: rtl/ct_lsu_pfu_pe_arb_if.sv
// Prefetch-engine arbiter bus: per-entry PFB requests in, shared MMU/BIU ports out.
// master = arbiter side, slave = PFB entries plus MMU/BIU environment.
interface ct_lsu_pfu_pe_arb_if #(
  parameter int ENTRY_NUM = 9,
  parameter int ID_W      = 4,
  parameter int VPN_W     = 28,
  parameter int ADDR_W    = 40,
  parameter int PPN_W     = 28
);
  logic                        pfu_pop_all_vld;
  logic [ENTRY_NUM-1:0]        pfb_mmu_req;
  logic [ENTRY_NUM-1:0]        pfb_mmu_req_l1;
  logic [ENTRY_NUM*VPN_W-1:0]  pfb_vpn;
  logic                        pfu_mmu_req;
  logic [VPN_W-1:0]            pfu_mmu_req_vpn;
  logic                        mmu_pfu_req_grnt;
  logic                        mmu_pfu_ppn_vld;
  logic [PPN_W-1:0]            mmu_pfu_ppn;
  logic                        mmu_pfu_ppn_err;
  logic [ENTRY_NUM-1:0]        pfb_get_ppn_vld;
  logic [PPN_W-1:0]            pfu_get_ppn;
  logic                        pfu_get_ppn_err;
  logic                        pfu_get_ppn_l1;
  logic [ENTRY_NUM-1:0]        pfb_biu_req;
  logic [ENTRY_NUM-1:0]        pfb_biu_req_l1;
  logic [ENTRY_NUM*ADDR_W-1:0] pfb_biu_addr;
  logic                        pfu_biu_req;
  logic [ADDR_W-1:0]           pfu_biu_req_addr;
  logic                        pfu_biu_req_l1;
  logic [ID_W-1:0]             pfu_biu_req_id;
  logic                        biu_pfu_req_grnt;
  logic [ENTRY_NUM-1:0]        pfb_biu_grnt;

  modport master (
    input  pfu_pop_all_vld, pfb_mmu_req, pfb_mmu_req_l1, pfb_vpn,
           mmu_pfu_req_grnt, mmu_pfu_ppn_vld, mmu_pfu_ppn, mmu_pfu_ppn_err,
           pfb_biu_req, pfb_biu_req_l1, pfb_biu_addr, biu_pfu_req_grnt,
    output pfu_mmu_req, pfu_mmu_req_vpn, pfb_get_ppn_vld, pfu_get_ppn,
           pfu_get_ppn_err, pfu_get_ppn_l1, pfu_biu_req, pfu_biu_req_addr,
           pfu_biu_req_l1, pfu_biu_req_id, pfb_biu_grnt
  );

  modport slave (
    output pfu_pop_all_vld, pfb_mmu_req, pfb_mmu_req_l1, pfb_vpn,
           mmu_pfu_req_grnt, mmu_pfu_ppn_vld, mmu_pfu_ppn, mmu_pfu_ppn_err,
           pfb_biu_req, pfb_biu_req_l1, pfb_biu_addr, biu_pfu_req_grnt,
    input  pfu_mmu_req, pfu_mmu_req_vpn, pfb_get_ppn_vld, pfu_get_ppn,
           pfu_get_ppn_err, pfu_get_ppn_l1, pfu_biu_req, pfu_biu_req_addr,
           pfu_biu_req_l1, pfu_biu_req_id, pfb_biu_grnt
  );
endinterface

// File: rtl/ct_lsu_pfu_pe_arb.sv
// Round-robin sharing of the MMU translation port and BIU prefetch port among PFB/GPFB entries.
// MMU side: single-outstanding FSM; BIU side: one-deep holding register issuing up to one per cycle.
module ct_lsu_pfu_pe_arb #(
  parameter int ENTRY_NUM = 9,
  parameter int ID_W      = 4,
  parameter int VPN_W     = 28,
  parameter int ADDR_W    = 40
) (
  input logic                forever_cpuclk,
  input logic                cpurst_b,
  ct_lsu_pfu_pe_arb_if.master bus
);
  localparam int PPN_W = 28;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} mmu_st_e;

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(ENTRY_NUM - 1)) ? '0 : id + ID_W'(1);
  endfunction

  function automatic logic [ENTRY_NUM-1:0] onehot(input logic [ID_W-1:0] id);
    return ENTRY_NUM'(1) << id;
  endfunction

  // First requester at or after start, wrapping at ENTRY_NUM-1.
  function automatic void rr_pick(input  logic [ENTRY_NUM-1:0] req,
                                  input  logic [ID_W-1:0]      start,
                                  output logic                 found,
                                  output logic [ID_W-1:0]      win);
    logic [ID_W:0] idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      idx = {1'b0, start} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(ENTRY_NUM)) idx = idx - (ID_W+1)'(ENTRY_NUM);
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  endfunction

  mmu_st_e              mmu_st_q, mmu_st_d;
  logic [ID_W-1:0]      mmu_ptr_q, mmu_ptr_d, owner_q, owner_d;
  logic [VPN_W-1:0]     vpn_q, vpn_d;
  logic                 l1_q, l1_d;
  logic [ENTRY_NUM-1:0] get_vld_q, get_vld_d;
  logic [PPN_W-1:0]     get_ppn_q, get_ppn_d;
  logic                 get_err_q, get_err_d, get_l1_q, get_l1_d;
  logic                 mmu_found;
  logic [ID_W-1:0]      mmu_win;

  always_comb begin
    rr_pick(bus.pfb_mmu_req, mmu_ptr_q, mmu_found, mmu_win);
  end

  always_comb begin
    mmu_st_d  = mmu_st_q;
    mmu_ptr_d = mmu_ptr_q;
    owner_d   = owner_q;
    vpn_d     = vpn_q;
    l1_d      = l1_q;
    get_vld_d = '0;
    get_ppn_d = get_ppn_q;
    get_err_d = get_err_q;
    get_l1_d  = get_l1_q;
    case (mmu_st_q)
      // Skip the strobe cycle so the just-served owner can drop its request first.
      IDLE: if (mmu_found && !bus.pfu_pop_all_vld && !(|get_vld_q)) begin
        owner_d  = mmu_win;
        vpn_d    = bus.pfb_vpn[mmu_win*VPN_W +: VPN_W];
        l1_d     = bus.pfb_mmu_req_l1[mmu_win];
        mmu_st_d = REQ;
      end
      REQ: if (bus.mmu_pfu_req_grnt) begin
        mmu_ptr_d = inc_id(owner_q);
        mmu_st_d  = bus.pfu_pop_all_vld ? FLUSH : WAIT;
      end else if (bus.pfu_pop_all_vld || !bus.pfb_mmu_req[owner_q]) begin
        mmu_st_d = IDLE;
      end
      WAIT: if (bus.mmu_pfu_ppn_vld) begin
        mmu_st_d = IDLE;
        if (!bus.pfu_pop_all_vld) begin
          get_vld_d = onehot(owner_q);
          get_ppn_d = bus.mmu_pfu_ppn;
          get_err_d = bus.mmu_pfu_ppn_err;
          get_l1_d  = l1_q;
        end
      end else if (bus.pfu_pop_all_vld) begin
        mmu_st_d = FLUSH;
      end
      FLUSH: if (bus.mmu_pfu_ppn_vld) mmu_st_d = IDLE;
      default: mmu_st_d = IDLE;
    endcase
  end

  logic                 biu_vld_q, biu_vld_d, biu_l1_q, biu_l1_d;
  logic [ID_W-1:0]      biu_id_q, biu_id_d, biu_ptr_q, biu_ptr_d;
  logic [ADDR_W-1:0]    biu_addr_q, biu_addr_d;
  logic                 biu_fire, biu_found;
  logic [ID_W-1:0]      biu_win, biu_start;
  logic [ENTRY_NUM-1:0] biu_cand;

  // On a grant the refill scans from the post-grant pointer and never re-picks the granted entry.
  assign biu_fire  = biu_vld_q & bus.biu_pfu_req_grnt;
  assign biu_start = biu_fire ? inc_id(biu_id_q) : biu_ptr_q;
  assign biu_cand  = bus.pfb_biu_req & ~(biu_fire ? onehot(biu_id_q) : '0);

  always_comb begin
    rr_pick(biu_cand, biu_start, biu_found, biu_win);
  end

  always_comb begin
    biu_vld_d  = biu_vld_q;
    biu_id_d   = biu_id_q;
    biu_addr_d = biu_addr_q;
    biu_l1_d   = biu_l1_q;
    biu_ptr_d  = biu_fire ? inc_id(biu_id_q) : biu_ptr_q;
    if (bus.pfu_pop_all_vld) begin
      biu_vld_d = 1'b0;
    end else if (!biu_vld_q || biu_fire) begin
      biu_vld_d = biu_found;
      if (biu_found) begin
        biu_id_d   = biu_win;
        biu_addr_d = bus.pfb_biu_addr[biu_win*ADDR_W +: ADDR_W];
        biu_l1_d   = bus.pfb_biu_req_l1[biu_win];
      end
    end else if (!bus.pfb_biu_req[biu_id_q]) begin
      biu_vld_d = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      mmu_st_q   <= IDLE;
      mmu_ptr_q  <= '0;
      owner_q    <= '0;
      vpn_q      <= '0;
      l1_q       <= 1'b0;
      get_vld_q  <= '0;
      get_ppn_q  <= '0;
      get_err_q  <= 1'b0;
      get_l1_q   <= 1'b0;
      biu_vld_q  <= 1'b0;
      biu_id_q   <= '0;
      biu_addr_q <= '0;
      biu_l1_q   <= 1'b0;
      biu_ptr_q  <= '0;
    end else begin
      mmu_st_q   <= mmu_st_d;
      mmu_ptr_q  <= mmu_ptr_d;
      owner_q    <= owner_d;
      vpn_q      <= vpn_d;
      l1_q       <= l1_d;
      get_vld_q  <= get_vld_d;
      get_ppn_q  <= get_ppn_d;
      get_err_q  <= get_err_d;
      get_l1_q   <= get_l1_d;
      biu_vld_q  <= biu_vld_d;
      biu_id_q   <= biu_id_d;
      biu_addr_q <= biu_addr_d;
      biu_l1_q   <= biu_l1_d;
      biu_ptr_q  <= biu_ptr_d;
    end
  end

  assign bus.pfu_mmu_req      = (mmu_st_q == REQ);
  assign bus.pfu_mmu_req_vpn  = vpn_q;
  assign bus.pfb_get_ppn_vld  = get_vld_q;
  assign bus.pfu_get_ppn      = get_ppn_q;
  assign bus.pfu_get_ppn_err  = get_err_q;
  assign bus.pfu_get_ppn_l1   = get_l1_q;
  assign bus.pfu_biu_req      = biu_vld_q;
  assign bus.pfu_biu_req_addr = biu_addr_q;
  assign bus.pfu_biu_req_l1   = biu_l1_q;
  assign bus.pfu_biu_req_id   = biu_id_q;
  assign bus.pfb_biu_grnt     = biu_fire ? onehot(biu_id_q) : '0;
endmodule

// File: tb/tb_ct_lsu_pfu_pe_arb.sv
// Directed bench for the PFU prefetch-engine arbiter: MMU FSM, BIU holding register, flush and reset.
module tb_ct_lsu_pfu_pe_arb;
  localparam int EN = 9, IDW = 4, VW = 28, AW = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  ct_lsu_pfu_pe_arb_if #(.ENTRY_NUM(EN), .ID_W(IDW), .VPN_W(VW), .ADDR_W(AW)) bus();

  ct_lsu_pfu_pe_arb #(.ENTRY_NUM(EN), .ID_W(IDW), .VPN_W(VW), .ADDR_W(AW)) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .bus           (bus)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_vpn(input int i, input logic [VW-1:0] v);
    bus.pfb_vpn[i*VW +: VW] = v;
  endtask

  task set_addr(input int i, input logic [AW-1:0] a);
    bus.pfb_biu_addr[i*AW +: AW] = a;
  endtask

  task test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.pfu_mmu_req, bus.pfu_get_ppn_err, bus.pfu_get_ppn_l1, bus.pfu_biu_req, bus.pfu_biu_req_l1} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {bus.pfu_mmu_req, bus.pfu_get_ppn_err,
        bus.pfu_get_ppn_l1, bus.pfu_biu_req, bus.pfu_biu_req_l1});
    end
    checks++;
    if (bus.pfu_mmu_req_vpn !== 28'h0 || bus.pfu_get_ppn !== 28'h0) begin
      failures++; $display("FAIL reset_vpn_ppn: got %h/%h want 0/0", bus.pfu_mmu_req_vpn, bus.pfu_get_ppn);
    end
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h0 || bus.pfb_biu_grnt !== 9'h0) begin
      failures++; $display("FAIL reset_strobes: got %h/%h want 0/0", bus.pfb_get_ppn_vld, bus.pfb_biu_grnt);
    end
    checks++;
    if (bus.pfu_biu_req_addr !== 40'h0 || bus.pfu_biu_req_id !== 4'h0) begin
      failures++; $display("FAIL reset_biu: got %h/%h want 0/0", bus.pfu_biu_req_addr, bus.pfu_biu_req_id);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task test_mmu_basic;
    bus.pfb_mmu_req[3] = 1'b1; bus.pfb_mmu_req_l1[3] = 1'b1; set_vpn(3, 28'h1234567);
    #1;
    checks++;
    if (bus.pfu_mmu_req !== 1'b0) begin failures++; $display("FAIL mmu_no_comb_req: got %b want 0", bus.pfu_mmu_req); end
    tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h1234567) begin
      failures++; $display("FAIL mmu_req_e3: got %b/%h want 1/1234567", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    bus.mmu_pfu_req_grnt = 1'b1;
    tick();
    bus.mmu_pfu_req_grnt = 1'b0;
    checks++;
    if (bus.pfu_mmu_req !== 1'b0) begin failures++; $display("FAIL mmu_wait_req: got %b want 0", bus.pfu_mmu_req); end
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'hABCDEF0; bus.mmu_pfu_ppn_err = 1'b0;
    tick();
    bus.mmu_pfu_ppn_vld = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h008 || bus.pfu_get_ppn !== 28'hABCDEF0 || bus.pfu_get_ppn_l1 !== 1'b1 || bus.pfu_get_ppn_err !== 1'b0) begin
      failures++; $display("FAIL mmu_resp_e3: got vld=%h ppn=%h l1=%b err=%b want 008/abcdef0/1/0",
        bus.pfb_get_ppn_vld, bus.pfu_get_ppn, bus.pfu_get_ppn_l1, bus.pfu_get_ppn_err);
    end
    bus.pfb_mmu_req[3] = 1'b0;
    tick();
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h0 || bus.pfu_get_ppn !== 28'hABCDEF0 || bus.pfu_mmu_req !== 1'b0) begin
      failures++; $display("FAIL mmu_resp_pulse: got vld=%h ppn=%h req=%b want 0/abcdef0/0",
        bus.pfb_get_ppn_vld, bus.pfu_get_ppn, bus.pfu_mmu_req);
    end
  endtask

  task test_mmu_wrap;
    // entry 7 moves the MMU pointer from 4 to 8
    bus.pfb_mmu_req[7] = 1'b1; set_vpn(7, 28'h0777000);
    tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h0777000) begin
      failures++; $display("FAIL wrap_e7_req: got %b/%h want 1/0777000", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    bus.mmu_pfu_req_grnt = 1'b1; tick(); bus.mmu_pfu_req_grnt = 1'b0;
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'h0000777; tick(); bus.mmu_pfu_ppn_vld = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h080) begin failures++; $display("FAIL wrap_e7_resp: got %h want 080", bus.pfb_get_ppn_vld); end
    bus.pfb_mmu_req[7] = 1'b0;
    bus.pfb_mmu_req[8] = 1'b1; set_vpn(8, 28'h0888000);
    bus.pfb_mmu_req[1] = 1'b1; set_vpn(1, 28'h0111000);
    for (int k = 0; k < 4 && bus.pfu_mmu_req !== 1'b1; k++) tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h0888000) begin
      failures++; $display("FAIL wrap_e8_first: got %b/%h want 1/0888000", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    bus.mmu_pfu_req_grnt = 1'b1; tick(); bus.mmu_pfu_req_grnt = 1'b0;
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'h0000888; tick(); bus.mmu_pfu_ppn_vld = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h100 || bus.pfu_get_ppn !== 28'h0000888) begin
      failures++; $display("FAIL wrap_e8_resp: got %h/%h want 100/0000888", bus.pfb_get_ppn_vld, bus.pfu_get_ppn);
    end
    bus.pfb_mmu_req[8] = 1'b0;
    for (int k = 0; k < 4 && bus.pfu_mmu_req !== 1'b1; k++) tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h0111000) begin
      failures++; $display("FAIL wrap_e1_second: got %b/%h want 1/0111000", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    bus.mmu_pfu_req_grnt = 1'b1; tick(); bus.mmu_pfu_req_grnt = 1'b0;
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'h0000111; tick(); bus.mmu_pfu_ppn_vld = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h002 || bus.pfu_get_ppn_l1 !== 1'b0) begin
      failures++; $display("FAIL wrap_e1_resp: got %h/%b want 002/0", bus.pfb_get_ppn_vld, bus.pfu_get_ppn_l1);
    end
    bus.pfb_mmu_req[1] = 1'b0;
  endtask

  task automatic test_biu_back_to_back;
    logic [IDW-1:0] exp_id [4];
    logic [EN-1:0]  exp_g  [4];
    logic [AW-1:0]  exp_a  [4];
    logic           exp_l1 [4];
    exp_id = '{4'd0, 4'd4, 4'd8, 4'd0};
    exp_g  = '{9'h001, 9'h010, 9'h100, 9'h001};
    exp_a  = '{40'h00_1000_0000, 40'h00_2000_0040, 40'hFF_0000_0100, 40'h00_1000_0000};
    exp_l1 = '{1'b1, 1'b0, 1'b1, 1'b1};
    set_addr(0, 40'h00_1000_0000); bus.pfb_biu_req_l1[0] = 1'b1;
    set_addr(4, 40'h00_2000_0040); bus.pfb_biu_req_l1[4] = 1'b0;
    set_addr(8, 40'hFF_0000_0100); bus.pfb_biu_req_l1[8] = 1'b1;
    bus.pfb_biu_req = 9'h111;
    bus.biu_pfu_req_grnt = 1'b1;
    #1;
    checks++;
    if (bus.pfb_biu_grnt !== 9'h0) begin failures++; $display("FAIL biu_empty_grnt: got %h want 0", bus.pfb_biu_grnt); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.pfu_biu_req !== 1'b1 || bus.pfu_biu_req_id !== exp_id[k] || bus.pfb_biu_grnt !== exp_g[k] ||
          bus.pfu_biu_req_addr !== exp_a[k] || bus.pfu_biu_req_l1 !== exp_l1[k]) begin
        failures++; $display("FAIL biu_b2b[%0d]: got req=%b id=%0d g=%h a=%h l1=%b want 1/%0d/%h/%h/%b", k,
          bus.pfu_biu_req, bus.pfu_biu_req_id, bus.pfb_biu_grnt, bus.pfu_biu_req_addr, bus.pfu_biu_req_l1,
          exp_id[k], exp_g[k], exp_a[k], exp_l1[k]);
      end
    end
    bus.biu_pfu_req_grnt = 1'b0;
    bus.pfb_biu_req = 9'h0;
    tick();
    checks++;
    if (bus.pfu_biu_req !== 1'b0) begin failures++; $display("FAIL biu_b2b_drain: got %b want 0", bus.pfu_biu_req); end
  endtask

  task test_biu_stall;
    set_addr(5, 40'h12_3456_7890); bus.pfb_biu_req_l1[5] = 1'b1;
    set_addr(6, 40'h00_0000_6600); bus.pfb_biu_req_l1[6] = 1'b0;
    bus.pfb_biu_req[5] = 1'b1; bus.pfb_biu_req[6] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.pfu_biu_req !== 1'b1 || bus.pfu_biu_req_id !== 4'd5 || bus.pfu_biu_req_addr !== 40'h12_3456_7890 ||
          bus.pfu_biu_req_l1 !== 1'b1 || bus.pfb_biu_grnt !== 9'h0) begin
        failures++; $display("FAIL biu_stall[%0d]: got req=%b id=%0d a=%h l1=%b g=%h want 1/5/1234567890/1/0", k,
          bus.pfu_biu_req, bus.pfu_biu_req_id, bus.pfu_biu_req_addr, bus.pfu_biu_req_l1, bus.pfb_biu_grnt);
      end
      if (k == 0) set_addr(5, 40'hAA_AAAA_AAAA);
      tick();
    end
    bus.pfb_biu_req[5] = 1'b0;
    tick();
    checks++;
    if (bus.pfu_biu_req !== 1'b0 || bus.pfb_biu_grnt !== 9'h0) begin
      failures++; $display("FAIL biu_withdraw: got req=%b g=%h want 0/0", bus.pfu_biu_req, bus.pfb_biu_grnt);
    end
    tick();
    checks++;
    if (bus.pfu_biu_req !== 1'b1 || bus.pfu_biu_req_id !== 4'd6) begin
      failures++; $display("FAIL biu_reload_e6: got %b/%0d want 1/6", bus.pfu_biu_req, bus.pfu_biu_req_id);
    end
  endtask

  task test_mmu_flush;
    bus.pfb_mmu_req[2] = 1'b1; set_vpn(2, 28'h0222000);
    for (int k = 0; k < 4 && bus.pfu_mmu_req !== 1'b1; k++) tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h0222000) begin
      failures++; $display("FAIL flush_e2_req: got %b/%h want 1/0222000", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    bus.mmu_pfu_req_grnt = 1'b1; tick(); bus.mmu_pfu_req_grnt = 1'b0;
    bus.pfu_pop_all_vld = 1'b1; tick(); bus.pfu_pop_all_vld = 1'b0;
    bus.pfb_mmu_req[2] = 1'b0;
    checks++;
    if (bus.pfu_biu_req !== 1'b0 || bus.pfu_mmu_req !== 1'b0) begin
      failures++; $display("FAIL flush_pop_clear: got biu=%b mmu=%b want 0/0", bus.pfu_biu_req, bus.pfu_mmu_req);
    end
    tick();
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'h5555555; bus.mmu_pfu_ppn_err = 1'b1;
    tick();
    bus.mmu_pfu_ppn_vld = 1'b0; bus.mmu_pfu_ppn_err = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h0 || bus.pfu_get_ppn !== 28'h0000111 || bus.pfu_get_ppn_err !== 1'b0) begin
      failures++; $display("FAIL flush_drop: got vld=%h ppn=%h err=%b want 0/0000111/0",
        bus.pfb_get_ppn_vld, bus.pfu_get_ppn, bus.pfu_get_ppn_err);
    end
    bus.pfb_mmu_req[5] = 1'b1; set_vpn(5, 28'h0555000);
    tick();
    checks++;
    if (bus.pfu_mmu_req !== 1'b1 || bus.pfu_mmu_req_vpn !== 28'h0555000) begin
      failures++; $display("FAIL flush_back_idle: got %b/%h want 1/0555000", bus.pfu_mmu_req, bus.pfu_mmu_req_vpn);
    end
    checks++;
    if (bus.pfu_biu_req !== 1'b1 || bus.pfu_biu_req_id !== 4'd6) begin
      failures++; $display("FAIL flush_biu_reload: got %b/%0d want 1/6", bus.pfu_biu_req, bus.pfu_biu_req_id);
    end
    bus.mmu_pfu_req_grnt = 1'b1; tick(); bus.mmu_pfu_req_grnt = 1'b0;
  endtask

  task test_reset_in_wait;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pfu_mmu_req, bus.pfu_biu_req, bus.pfu_get_ppn_l1, bus.pfu_biu_req_l1} !== 4'b0 ||
        bus.pfu_mmu_req_vpn !== 28'h0 || bus.pfu_get_ppn !== 28'h0) begin
      failures++; $display("FAIL rst_async_mmu: got req=%b biu=%b vpn=%h ppn=%h want 0/0/0/0",
        bus.pfu_mmu_req, bus.pfu_biu_req, bus.pfu_mmu_req_vpn, bus.pfu_get_ppn);
    end
    checks++;
    if (bus.pfu_biu_req_id !== 4'h0 || bus.pfu_biu_req_addr !== 40'h0 || bus.pfb_get_ppn_vld !== 9'h0 || bus.pfb_biu_grnt !== 9'h0) begin
      failures++; $display("FAIL rst_async_biu: got id=%0d a=%h vld=%h g=%h want 0/0/0/0",
        bus.pfu_biu_req_id, bus.pfu_biu_req_addr, bus.pfb_get_ppn_vld, bus.pfb_biu_grnt);
    end
    bus.pfb_mmu_req = '0; bus.pfb_biu_req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.mmu_pfu_ppn_vld = 1'b1; bus.mmu_pfu_ppn = 28'h0FEDCBA;
    tick();
    bus.mmu_pfu_ppn_vld = 1'b0;
    checks++;
    if (bus.pfb_get_ppn_vld !== 9'h0 || bus.pfu_get_ppn !== 28'h0 || bus.pfu_mmu_req !== 1'b0) begin
      failures++; $display("FAIL rst_late_resp: got vld=%h ppn=%h req=%b want 0/0/0",
        bus.pfb_get_ppn_vld, bus.pfu_get_ppn, bus.pfu_mmu_req);
    end
  endtask

  initial begin
    bus.pfu_pop_all_vld  = 1'b0;
    bus.pfb_mmu_req      = '0;
    bus.pfb_mmu_req_l1   = '0;
    bus.pfb_vpn          = '0;
    bus.mmu_pfu_req_grnt = 1'b0;
    bus.mmu_pfu_ppn_vld  = 1'b0;
    bus.mmu_pfu_ppn      = '0;
    bus.mmu_pfu_ppn_err  = 1'b0;
    bus.pfb_biu_req      = '0;
    bus.pfb_biu_req_l1   = '0;
    bus.pfb_biu_addr     = '0;
    bus.biu_pfu_req_grnt = 1'b0;
    test_reset();
    test_mmu_basic();
    test_mmu_wrap();
    test_biu_back_to_back();
    test_biu_stall();
    test_mmu_flush();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
